// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Generic pipeline-stage register with valid/ready handshake,
//               stall and flush. A stage with no valid entry always presents
//               all-zero control, so bubbles never write registers or memory.
//               Optional one-entry skid buffer (build macro
//               PIPE_STAGE_SKID_EN) gives a registered in_ready at full
//               throughput.
// Ports       : clk        rising-edge clock
//               rst        asynchronous reset, active-high
//               flush      discard held entries and any same-cycle input
//               in_valid   upstream entry valid
//               in_ready   stage can accept an entry this cycle
//               in_data    upstream payload            [DATA_W]
//               in_ctrl    upstream control bundle     [CTRL_W]
//               out_valid  entry presented downstream
//               out_ready  downstream accepts (0 = stall)
//               out_data   payload to next stage       [DATA_W]
//               out_ctrl   control to next stage, zero when out_valid=0
//               occupancy  entries held (0..1, or 0..2 with skid)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 12,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_retire;

    assign w_retire = r_main_valid & out_ready;
    assign w_accept = in_valid & w_in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    // Ready depends only on a register: no combinational path from out_ready.
    assign w_in_ready = ~r_skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            if (CLR_DATA) begin
                r_main_data <= '0;
            end
        end else if (!r_main_valid || w_retire) begin
            // Main slot frees up: the older skid entry has priority over the
            // input. Accept and a full skid are mutually exclusive.
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_main_ctrl  <= r_skid_ctrl;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
                r_main_ctrl  <= in_ctrl;
            end else begin
                r_main_valid <= 1'b0;
                r_main_ctrl  <= '0;
                if (CLR_DATA) begin
                    r_main_data <= '0;
                end
            end
        end else if (w_accept) begin
            // Main full and stalled: park the entry in the skid slot.
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
            r_skid_ctrl  <= in_ctrl;
        end
    end

    assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
`else
    // Single entry: a full stage can only accept while it retires.
    assign w_in_ready = ~r_main_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            if (CLR_DATA) begin
                r_main_data <= '0;
            end
        end else if (w_accept) begin
            r_main_valid <= 1'b1;
            r_main_data  <= in_data;
            r_main_ctrl  <= in_ctrl;
        end else if (w_retire) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            if (CLR_DATA) begin
                r_main_data <= '0;
            end
        end
    end

    assign occupancy = {1'b0, r_main_valid};
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    // Control register is cleared on every path that empties the stage.
    assign out_ctrl  = r_main_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Self-checking bench for pipe_stage_buf. A FIFO queue of
//               bounded capacity serves as reference model. Honours the
//               PIPE_STAGE_SKID_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_SKID_EN
    localparam int c_CAP = 2;
`else
    localparam int c_CAP = 1;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [11:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [11:0] out_ctrl;
    logic [1:0]  occupancy;

    pipe_stage_buf #(
        .DATA_W   (32),
        .CTRL_W   (12),
        .CLR_DATA (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO of held entries plus the last payload presented.
    logic [31:0] q_d[$];
    logic [11:0] q_c[$];
    logic [31:0] last_d = '0;

    function automatic logic m_in_ready(input logic ordy);
        if (c_CAP == 2) return q_d.size() < 2;
        return (q_d.size() == 0) || ordy;
    endfunction

    function automatic logic m_valid();
        return q_d.size() > 0;
    endfunction

    function automatic logic [31:0] m_data();
        return (q_d.size() > 0) ? q_d[0] : last_d;
    endfunction

    function automatic logic [11:0] m_ctrl();
        return (q_c.size() > 0) ? q_c[0] : 12'h000;
    endfunction

    function automatic logic [1:0] m_occ();
        return 2'(q_d.size());
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic [11:0] c,
                         input logic r, input logic f);
        in_valid  = v;
        out_ready = r;
        flush     = f;
        if (v) begin
            in_data = d;
            in_ctrl = c;
        end else begin
            in_data = 'x;
            in_ctrl = 'x;
        end
    endtask

    // Advance one clock and update the model from the inputs held over the edge.
    task automatic tick();
        logic acc;
        logic ret;
        logic [31:0] d;
        logic [11:0] c;
        acc = in_valid && m_in_ready(out_ready);
        ret = (q_d.size() > 0) && out_ready;
        d   = in_data;
        c   = in_ctrl;
        @(posedge clk);
        if (flush) begin
            q_d.delete();
            q_c.delete();
        end else begin
            if (ret) begin
                void'(q_d.pop_front());
                void'(q_c.pop_front());
            end
            if (acc) begin
                q_d.push_back(d);
                q_c.push_back(c);
            end
            if (q_d.size() > 0) last_d = q_d[0];
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_ctrl !== 12'h000) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 000", out_ctrl); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        // Load an entry, stall it, then reset asynchronously mid-cycle.
        drive(1'b1, 32'h55, 12'hABC, 1'b0, 1'b0);
        tick();
        n_checks++; if (out_ctrl !== 12'hABC) begin n_fail++; $display("FAIL pre_rst_ctrl: got %h expected abc", out_ctrl); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid: got %b expected 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_ctrl !== 12'h000) begin n_fail++; $display("FAIL midrst_ctrl: got %h expected 000", out_ctrl); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL midrst_occ: got %0d expected 0", occupancy); end
        q_d.delete();
        q_c.delete();
        last_d = '0;
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i), 12'(i * 3 + 1), 1'b1, 1'b0);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
            n_checks++; if (out_data !== 32'(i)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_data, 32'(i)); end
            n_checks++; if (out_ctrl !== 12'(i * 3 + 1)) begin n_fail++; $display("FAIL stream_ctrl[%0d]: got %h expected %h", i, out_ctrl, 12'(i * 3 + 1)); end
            n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i, occupancy); end
        end
    endtask

    task automatic test_stall();
        logic exp_rdy;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h10, 12'h111, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h14, 12'h222, 1'b0, 1'b0);
            #1;
            exp_rdy = (c_CAP == 2) && (k == 0);
            n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy); end
            tick();
            n_checks++; if (out_data !== 32'h10) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected 10", k, out_data); end
            n_checks++; if (out_ctrl !== 12'h111) begin n_fail++; $display("FAIL stall_ctrl[%0d]: got %h expected 111", k, out_ctrl); end
            n_checks++; if (occupancy !== 2'(c_CAP)) begin n_fail++; $display("FAIL stall_occ[%0d]: got %0d expected %0d", k, occupancy, c_CAP); end
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        n_checks++; if (out_valid !== (c_CAP == 2)) begin n_fail++; $display("FAIL release_valid: got %b expected %b", out_valid, c_CAP == 2); end
        n_checks++; if (out_data !== ((c_CAP == 2) ? 32'h14 : 32'h10)) begin n_fail++; $display("FAIL release_data: got %h expected %h", out_data, (c_CAP == 2) ? 32'h14 : 32'h10); end
        n_checks++; if (out_ctrl !== m_ctrl()) begin n_fail++; $display("FAIL release_ctrl: got %h expected %h", out_ctrl, m_ctrl()); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b expected 0", out_valid); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL drained_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h20, 12'h333, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h24, 12'h444, 1'b0, 1'b0);
        tick();
        n_checks++; if (occupancy !== 2'(c_CAP)) begin n_fail++; $display("FAIL preflush_occ: got %0d expected %0d", occupancy, c_CAP); end
        drive(1'b1, 32'hDEAD, 12'hFFF, 1'b1, 1'b1);
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_ctrl !== 12'h000) begin n_fail++; $display("FAIL flush_ctrl: got %h expected 000", out_ctrl); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
        n_checks++; if (out_data !== 32'h20) begin n_fail++; $display("FAIL flush_data_hold: got %h expected 20", out_data); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL postflush_valid[%0d]: got %b expected 0", k, out_valid); end
        end
    endtask

    task automatic test_bubble();
        drive(1'b1, 32'hA0A0, 12'h5A5, 1'b1, 1'b0);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA0A0) begin n_fail++; $display("FAIL bubble_a: got valid %b data %h expected 1 a0a0", out_valid, out_data); end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_ctrl !== 12'h000) begin n_fail++; $display("FAIL bubble_ctrl: got %h expected 000", out_ctrl); end
        drive(1'b1, 32'hB0B0, 12'h3C3, 1'b1, 1'b0);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hB0B0) begin n_fail++; $display("FAIL bubble_b: got valid %b data %h expected 1 b0b0", out_valid, out_data); end
        n_checks++; if (out_ctrl !== 12'h3C3) begin n_fail++; $display("FAIL bubble_b_ctrl: got %h expected 3c3", out_ctrl); end
    endtask

    task automatic test_random();
        logic v, r, f;
        logic exp_rdy;
        for (int n = 0; n < 10000; n++) begin
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < 60);
            f = ($urandom_range(0, 99) < 4);
            drive(v, $urandom, 12'($urandom), r, f);
            #1;
            exp_rdy = m_in_ready(r);
            n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", n, in_ready, exp_rdy); end
            tick();
            n_checks++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, out_valid, m_valid()); end
            n_checks++; if (out_data !== m_data()) begin n_fail++; $display("FAIL rnd_data@%0d: got %h expected %h", n, out_data, m_data()); end
            n_checks++; if (out_ctrl !== m_ctrl()) begin n_fail++; $display("FAIL rnd_ctrl@%0d: got %h expected %h", n, out_ctrl, m_ctrl()); end
            n_checks++; if (occupancy !== m_occ()) begin n_fail++; $display("FAIL rnd_occ@%0d: got %0d expected %0d", n, occupancy, m_occ()); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_bubble();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
